period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_if.sv | 23 ++
 rtl/period_meter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/period_meter_if.sv
// Signal bundle for period_meter: the measured input, clear, and the measurement results.
// master drives sig_in/clr and observes results; slave is the meter itself.
interface period_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_vld;
  logic             locked;
  logic             timeout;

  modport master (
    output sig_in, clr,
    input  period, high_time, period_vld, locked, timeout
  );

  modport slave (
    input  sig_in, clr,
    output period, high_time, period_vld, locked, timeout
  );
endinterface

// File: rtl/period_meter.sv
// Measures rise-to-rise period and high time of an asynchronous signal in clk cycles.
// period_vld pulses on the 3rd clk edge after a sig_in rise; no backpressure, results just update.
module period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic {IDLE, MEAS} state_t;

  logic             s1, s2, s3;
  logic [2:0]       fill;
  logic             rise, fall;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] hcnt_q, hcnt_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic [CNT_W-1:0] high_q, high_nxt;
  logic             vld_q, vld_nxt;
  logic             locked_q, locked_nxt;
  logic             timeout_q, timeout_nxt;

  // fill marks when s3 holds a real sample, so a signal already high at reset release is not a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= 3'b000;
    end else begin
      s1   <= bus.sig_in;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end

  assign rise = s2 & ~s3 & fill[2];
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      hcnt_q    <= hcnt_nxt;
      period_q  <= period_nxt;
      high_q    <= high_nxt;
      vld_q     <= vld_nxt;
      locked_q  <= locked_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    hcnt_nxt    = hcnt_q;
    period_nxt  = period_q;
    high_nxt    = high_q;
    vld_nxt     = 1'b0;
    locked_nxt  = locked_q;
    timeout_nxt = timeout_q;

    if (bus.clr) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      hcnt_nxt    = '0;
      period_nxt  = '0;
      high_nxt    = '0;
      locked_nxt  = 1'b0;
      timeout_nxt = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_nxt = MEAS;
            cnt_nxt   = ONE;
            hcnt_nxt  = ONE;
          end
        end
        MEAS: begin
          // a rise on the TIMEOUT cycle still counts as a valid period
          if (rise) begin
            period_nxt = cnt_q;
            vld_nxt    = 1'b1;
            locked_nxt = 1'b1;
            cnt_nxt    = ONE;
            hcnt_nxt   = ONE;
          end else if (cnt_q == TO_CNT) begin
            state_nxt   = IDLE;
            locked_nxt  = 1'b0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q + ONE;
            if (s2) begin
              hcnt_nxt = hcnt_q + ONE;
            end
            if (fall) begin
              high_nxt = hcnt_q;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.period_vld = vld_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;

endmodule
